sound_sequencer: RTL
====================

# sound_sequencer

Parametrised event-to-tone sequencer for the snake game audio path. It sits between the game logic and the tone generator. It takes NUM_EVENTS level event inputs and one mute button, and detects rising edges on each. Edges are latched into a pending register and played back one at a time, highest priority first, as fixed-length tones with a configurable silent gap between them. A button edge toggles mute.

## Interface
- NUM_EVENTS, default 4: number of event channels; index 0 has the highest priority.
- FREQ_W, default 9: width of each frequency code.
- TONE_CYCLES, default 1000: length of each tone in clk cycles; must be ≥1.
- GAP_CYCLES, default 100: silent cycles between tones; 0 means no gap.
- clk  input  1  system clock; all state changes on posedge.
- nRst  input  1  asynchronous, active-high reset: 1 resets immediately, 0 runs.
- buttonPressed  input  1  mute toggle, level; acts on its rising edge only.
- evt  input  NUM_EVENTS  level event requests, one bit per channel.
- evtFreq  input  NUM_EVENTS*FREQ_W  frequency code per channel; channel i occupies bits [i*FREQ_W +: FREQ_W].
- playSound  output  1  tone enable.
- freq  output  FREQ_W  frequency of the current tone; 0 when not playing.
- activeEvent  output  $clog2(NUM_EVENTS)  index of the channel now playing.
- pending  output  NUM_EVENTS  latched, not-yet-played requests.
- mode_o  output  1  MODE_TYPES; ON = unmuted, OFF = muted.

## Operation
- Edge detection: registered evtPrev and btnPrev. edge = evt & ~evtPrev; btnEdge = buttonPressed & ~btnPrev.
- Pending register: next value = (pending & ~grantClear) | edge. When a set and a clear hit the same bit in the same cycle, the set wins.
- States:
  - IDLE: playSound=0. If pending≠0, grant the lowest-index set bit, clear it, load the counter with TONE_CYCLES-1, go to PLAY.
  - PLAY: playSound=1, freq = evtFreq slice of activeEvent. The counter decrements each cycle. At 0, go to GAP if GAP_CYCLES>0, else grant the next pending bit directly (back-to-back) or go to IDLE.
  - GAP: playSound=0, freq=0, counter loaded with GAP_CYCLES-1. At 0, go to IDLE.
  - MUTED: playSound=0, freq=0, mode_o=OFF. Edges are ignored and not latched; pending is held at 0.
- btnEdge in any unmuted state: go to MUTED next cycle, clear pending, abort any tone. This takes priority over all event edges in the same cycle.
- btnEdge in MUTED: go to IDLE with mode_o=ON. Event edges in that same cycle are discarded.
- Outputs are registered. playSound and freq change only on a state change.
- The counter has width $clog2(max(TONE_CYCLES,GAP_CYCLES)+1) and never wraps. Reloads happen only on state entry.

## Timing
- Reset values:
  - state = IDLE
  - mode_o = ON
  - pending = 0
  - playSound = 0
  - freq = 0
  - activeEvent = 0
  - evtPrev and btnPrev = 0: an input already high when reset releases counts as an edge.
- evt[i] rises before posedge t: pending[i]=1 after posedge t.
- From IDLE, playSound=1 after posedge t+1. That is 2 cycles from event to sound.
- A tone lasts exactly TONE_CYCLES cycles. A gap lasts exactly GAP_CYCLES cycles, plus 1 IDLE cycle before the next grant.
- Mute takes effect 1 cycle after the button edge, i.e. playSound=0 after the next posedge.
- A held evt or buttonPressed acts once. Re-triggering needs a low cycle.
- A new edge on the channel currently playing re-latches its pending bit, so the tone plays again later.
- Asserting reset mid-tone drops playSound to 0 asynchronously and discards pending.

## Configuration
- SOUND_PREEMPT_EN defined: in PLAY, a pending bit with a lower index than activeEvent aborts the current tone. The next cycle grants that channel, reloads the counter, and keeps playSound=1 with the new freq. The aborted channel is not re-queued.
- Not defined: tones always run to completion; higher-priority edges wait in pending.

## Structure
- Shared package snake_sound_pkg holds:
  - MODE_TYPES (OFF=0, ON=1);
  - the state enum SEQ_STATE_T (IDLE, PLAY, GAP, MUTED);
  - default note constants NOTE_C=262, NOTE_DS=311, NOTE_A=440.
- One natural sub-module: priority_encoder. It is parametrised on width and outputs the lowest set index plus a valid flag. The encoder is used for grants and for the preemption compare.

## Test plan
- Single event: reset, then pulse evt[2] with evtFreq slice 440, TONE_CYCLES=4, GAP_CYCLES=2. Required: playSound high for exactly 4 cycles starting 2 cycles after the edge, freq=440, activeEvent=2, then 2 gap cycles.
- Simultaneous events: evt[3] and evt[1] rise in the same cycle. Required: pending=4'b1010, channel 1 plays first, then channel 3 after the gap, then pending=0.
- Mute during tone: btnEdge in cycle 2 of a tone. Required: playSound=0 next cycle, mode_o=OFF, pending=0. evt edges while muted leave pending=0. A second btnEdge gives mode_o=ON and IDLE.
- Held inputs: evt[0] held high for 20 cycles. Required: exactly one tone.
- Back-to-back: GAP_CYCLES=0 with two pending channels. Required: playSound stays 1 across the boundary and freq switches in a single cycle.
- Preemption: with SOUND_PREEMPT_EN, evt[0] rises during channel 2's tone. Required: the next cycle shows activeEvent=0 and freq from slice 0, and channel 2 is not replayed. Without the macro, channel 2 completes and then channel 0 plays.

Source files
------------

// File: rtl/snake_sound_pkg.sv
// snake_sound_pkg: shared mode/state types and default note codes for the snake audio path
package snake_sound_pkg;
    typedef enum logic {OFF = 1'b0, ON = 1'b1} MODE_TYPES;
    typedef enum logic [1:0] {IDLE, PLAY, GAP, MUTED} SEQ_STATE_T;
    localparam int NOTE_C = 262;
    localparam int NOTE_DS = 311;
    localparam int NOTE_A = 440;
endpackage

// File: rtl/priority_encoder.sv
// priority_encoder: lowest set index of a request vector plus a valid flag
module priority_encoder #(
    parameter int W = 4,
    parameter int IW = (W > 1) ? $clog2(W) : 1
) (
    input  logic [W-1:0]  req,
    output logic [IW-1:0] idx,
    output logic          valid
);
    // scan downwards so the lowest set bit is the last one written
    always_comb begin
        idx = '0;
        for (int i = W - 1; i >= 0; i--)
            if (req[i]) idx = IW'(i);
        valid = |req;
    end
endmodule

// File: rtl/sound_sequencer.sv
// sound_sequencer: latches event edges and plays them one at a time as prioritised tones with gaps and mute
// Optional SOUND_PREEMPT_EN: a pending lower-index request aborts the tone now playing
module sound_sequencer
    import snake_sound_pkg::*;
#(
    parameter int NUM_EVENTS = 4,
    parameter int FREQ_W = 9,
    parameter int TONE_CYCLES = 1000,
    parameter int GAP_CYCLES = 100
) (
    input  logic                           clk,
    input  logic                           nRst,
    input  logic                           buttonPressed,
    input  logic [NUM_EVENTS-1:0]          evt,
    input  logic [NUM_EVENTS*FREQ_W-1:0]   evtFreq,
    output logic                           playSound,
    output logic [FREQ_W-1:0]              freq,
    output logic [$clog2(NUM_EVENTS)-1:0]  activeEvent,
    output logic [NUM_EVENTS-1:0]          pending,
    output MODE_TYPES                      mode_o
);
    localparam int AW = $clog2(NUM_EVENTS);
    localparam int CMAX = (TONE_CYCLES > GAP_CYCLES) ? TONE_CYCLES : GAP_CYCLES;
    localparam int CW = $clog2(CMAX + 1);

    SEQ_STATE_T state, state_n;
    logic [CW-1:0] cnt, cnt_n;
    logic [NUM_EVENTS-1:0] evt_prev, evt_edge, pend_n;
    logic btn_prev, btn_edge, grant, pvalid, preempt, play_n;
    logic [AW-1:0] pidx, act_n;
    logic [FREQ_W-1:0] freq_n;
    MODE_TYPES mode_n;

    assign evt_edge = evt & ~evt_prev;
    assign btn_edge = buttonPressed & ~btn_prev;

    priority_encoder #(.W(NUM_EVENTS), .IW(AW)) u_enc (
        .req(pending),
        .idx(pidx),
        .valid(pvalid)
    );

`ifdef SOUND_PREEMPT_EN
    assign preempt = pvalid && (pidx < activeEvent);
`else
    assign preempt = 1'b0;
`endif

    // state, counter, pending latch, edge history and registered outputs
    always_ff @(posedge clk or posedge nRst)
        if (nRst) begin
            state       <= IDLE;
            cnt         <= '0;
            evt_prev    <= '0;
            btn_prev    <= 1'b0;
            pending     <= '0;
            activeEvent <= '0;
            playSound   <= 1'b0;
            freq        <= '0;
            mode_o      <= ON;
        end else begin
            state       <= state_n;
            cnt         <= cnt_n;
            evt_prev    <= evt;
            btn_prev    <= buttonPressed;
            pending     <= pend_n;
            activeEvent <= act_n;
            playSound   <= play_n;
            freq        <= freq_n;
            mode_o      <= mode_n;
        end

    // sequencing: mute toggle first, then grants, tone countdown and gap countdown
    always_comb begin
        state_n = state;
        cnt_n = cnt;
        grant = 1'b0;
        if (btn_edge)
            state_n = (state == MUTED) ? IDLE : MUTED;
        else
            case (state)
                IDLE: grant = pvalid;
                PLAY:
                    if (preempt)
                        grant = 1'b1;
                    else if (cnt != '0)
                        cnt_n = cnt - 1'b1;
                    else if (GAP_CYCLES > 0) begin
                        state_n = GAP;
                        cnt_n = CW'(GAP_CYCLES - 1);
                    end else if (pvalid)
                        grant = 1'b1;
                    else
                        state_n = IDLE;
                GAP:
                    if (cnt != '0)
                        cnt_n = cnt - 1'b1;
                    else
                        state_n = IDLE;
                default: ;
            endcase
        if (grant) begin
            state_n = PLAY;
            cnt_n = CW'(TONE_CYCLES - 1);
        end
        act_n = grant ? pidx : activeEvent;
        pend_n = (state == MUTED || btn_edge) ? '0
               : (pending & ~(grant ? (NUM_EVENTS'(1) << pidx) : '0)) | evt_edge;
    end

    // next registered outputs; freq is captured at grant and held for the tone
    always_comb begin
        play_n = (state_n == PLAY);
        freq_n = !play_n ? '0 : grant ? evtFreq[pidx*FREQ_W +: FREQ_W] : freq;
        mode_n = (state_n == MUTED) ? OFF : ON;
    end
endmodule
